seg7_scan_capture: RTL and testbench



---
 rtl/seg7_scan_capture.sv | 112 +++++++++++
 tb/tb_seg7_scan_capture.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: rebuilds the 16-bit value shown on a scanned active-low 7-segment bus.
// Define FRAME_CHANGE_ONLY_EN to pulse value_valid only when the captured frame changes.
module seg7_scan_capture #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  hex_display,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [3:0]  dp,
  output logic        decode_err,
  output logic        scan_err,
  output logic        stale
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] WAIT = 2'd0, EVAL = 2'd1, HOLD = 2'd2;
  logic [3:0]    an_m, an_s, an_p, smp_an, mask, sel, nmask, dps, ndp;
  logic [7:0]    hx_m, hx_s, hx_p, smp_hx;
  logic [SW-1:0] stab;
  logic [TW-1:0] tcnt;
  logic [1:0]    st;
  logic [15:0]   slots, nslots;
  logic [4:0]    dec;
  logic          chg, settled, one_low, multi, good, bad, done, fresh;
  function automatic logic [4:0] glyph(input logic [6:0] s);
    case (s)
      7'h40: glyph = 5'h10;
      7'h79: glyph = 5'h11;
      7'h24: glyph = 5'h12;
      7'h30: glyph = 5'h13;
      7'h19: glyph = 5'h14;
      7'h12: glyph = 5'h15;
      7'h02: glyph = 5'h16;
      7'h78: glyph = 5'h17;
      7'h00: glyph = 5'h18;
      7'h10: glyph = 5'h19;
      7'h08: glyph = 5'h1A;
      7'h03: glyph = 5'h1B;
      7'h46: glyph = 5'h1C;
      7'h21: glyph = 5'h1D;
      7'h06: glyph = 5'h1E;
      7'h0E: glyph = 5'h1F;
      default: glyph = 5'h00;
    endcase
  endfunction
  always_comb begin
    chg     = {an_s, hx_s} != {an_p, hx_p};
    settled = stab == SW'(SETTLE_CYCLES);
    sel     = ~smp_an;
    one_low = $countones(sel) == 1;
    multi   = $countones(sel) > 1;
    dec     = glyph(smp_hx[6:0]);
    nmask   = mask | sel;
    nslots  = slots;
    ndp     = dps;
    for (int i = 0; i < 4; i++) begin
      nslots[4*i +: 4] = sel[i] ? dec[3:0] : slots[4*i +: 4];
      ndp[i]           = sel[i] ? ~smp_hx[7] : dps[i];
    end
    good  = st == EVAL && one_low && dec[4];
    bad   = st == EVAL && (multi || (one_low && !dec[4]));
    done  = good && nmask == 4'hF;
`ifdef FRAME_CHANGE_ONLY_EN
    fresh = {nslots, ndp} != {value, dp};
`else
    fresh = 1'b1;
`endif
  end
  assign stale = tcnt == TW'(TIMEOUT_CYCLES);
  // Blank bus as the synchroniser reset value so nothing is sampled out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {an_m, an_s, an_p, smp_an} <= '1;
      {hx_m, hx_s, hx_p, smp_hx} <= '1;
      stab <= '0;
      st   <= WAIT;
    end else begin
      {an_m, hx_m} <= {an, hex_display};
      {an_s, hx_s} <= {an_m, hx_m};
      {an_p, hx_p} <= {an_s, hx_s};
      stab <= chg ? '0 : settled ? stab : stab + 1'b1;
      st   <= st == WAIT ? (settled ? EVAL : WAIT) : st == EVAL ? HOLD : (settled ? HOLD : WAIT);
      if (st == WAIT && settled) {smp_an, smp_hx} <= {an_s, hx_s};
    end
  end
  // Final digit completes the frame straight from EVAL, giving one-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask        <= '0;
      slots       <= '0;
      dps         <= '0;
      value       <= '0;
      dp          <= '0;
      value_valid <= 1'b0;
      decode_err  <= 1'b0;
      scan_err    <= 1'b0;
      tcnt        <= '0;
    end else begin
      scan_err    <= st == EVAL && multi;
      decode_err  <= st == EVAL && one_low && !dec[4];
      value_valid <= done && fresh;
      mask        <= (bad || done) ? 4'h0 : good ? nmask : mask;
      if (good) {slots, dps} <= {nslots, ndp};
      if (done) {value, dp} <= {nslots, ndp};
      tcnt <= done ? '0 : stale ? tcnt : tcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed scans with hand-computed frames, errors and timeout.
module tb_seg7_scan_capture;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  hex_display = 8'hFF;
  logic [3:0]  an = 4'hF;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        value_valid, decode_err, scan_err, stale;
  int          errs = 0, checks = 0, n_vv = 0, n_de = 0, n_se = 0;
  int          b_vv, b_de, b_se;
  seg7_scan_capture #(.SETTLE_CYCLES(8), .TIMEOUT_CYCLES(60)) dut (
    .clk(clk), .rst(rst), .hex_display(hex_display), .an(an), .value(value),
    .value_valid(value_valid), .dp(dp), .decode_err(decode_err), .scan_err(scan_err), .stale(stale)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (value_valid) n_vv++;
    if (decode_err) n_de++;
    if (scan_err) n_se++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic dig(input logic [3:0] a, input logic [7:0] h, input int n);
    @(negedge clk);
    an = a;
    hex_display = h;
    repeat (n - 1) @(negedge clk);
  endtask
  task automatic snap();
    b_vv = n_vv;
    b_de = n_de;
    b_se = n_se;
  endtask
  // Input change lands 13 rising edges before value_valid: 2 sync + 9 settle + WAIT->EVAL + EVAL.
  task automatic fin(input logic [3:0] a, input logic [7:0] h, input string tag);
    @(negedge clk);
    an = a;
    hex_display = h;
    repeat (12) @(negedge clk);
    chk({tag, "_vv_early"}, value_valid, 0);
    chk({tag, "_stale_before"}, stale, 1);
    @(negedge clk);
    chk({tag, "_vv_pulse"}, value_valid, 1);
    chk({tag, "_stale_cleared"}, stale, 0);
    @(negedge clk);
    chk({tag, "_vv_one_cycle"}, value_valid, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_value", value, 0);
    chk("rst_vv", value_valid, 0);
    chk("rst_dp", dp, 0);
    chk("rst_de", decode_err, 0);
    chk("rst_se", scan_err, 0);
    chk("rst_stale", stale, 0);
    snap();
    repeat (3) begin
      dig(4'hE, 8'h99, 5); dig(4'hD, 8'hB0, 5); dig(4'hB, 8'hA4, 5); dig(4'h7, 8'hF9, 5);
    end
    dig(4'hF, 8'hFF, 20);
    chk("short_vv", n_vv - b_vv, 0);
    chk("short_err", (n_de - b_de) + (n_se - b_se), 0);
    chk("short_value", value, 0);
    snap();
    dig(4'hE, 8'h99, 20); dig(4'hD, 8'hB0, 20); dig(4'hB, 8'hA4, 20);
    fin(4'h7, 8'hF9, "f1234");
    dig(4'hF, 8'hFF, 20);
    chk("f1234_value", value, 16'h1234);
    chk("f1234_dp", dp, 0);
    chk("f1234_count", n_vv - b_vv, 1);
    snap();
    repeat (3) begin
      dig(4'hE, 8'h8E, 20); dig(4'hD, 8'h86, 20); dig(4'hB, 8'h86, 20); dig(4'h7, 8'h83, 20);
    end
    dig(4'hF, 8'hFF, 20);
    chk("beef_value", value, 16'hBEEF);
`ifdef FRAME_CHANGE_ONLY_EN
    chk("beef_count", n_vv - b_vv, 1);
`else
    chk("beef_count", n_vv - b_vv, 3);
`endif
    snap();
    dig(4'hE, 8'hC0, 20); dig(4'hC, 8'hC0, 20);
    dig(4'hD, 8'h08, 20); dig(4'hB, 8'hC0, 20); dig(4'h7, 8'hC0, 20); dig(4'hF, 8'hFF, 20);
    chk("scan_se", n_se - b_se, 1);
    chk("scan_de", n_de - b_de, 0);
    chk("scan_mask_cleared", n_vv - b_vv, 0);
    chk("scan_value_held", value, 16'hBEEF);
    dig(4'hE, 8'hC0, 20); dig(4'hF, 8'hFF, 20);
    chk("a0_count", n_vv - b_vv, 1);
    chk("a0_value", value, 16'h00A0);
    chk("a0_dp", dp, 4'b0010);
    snap();
    dig(4'hD, 8'hF8, 20); dig(4'hB, 8'h82, 20); dig(4'h7, 8'h92, 20);
    dig(4'hE, 8'hFF, 20); dig(4'hF, 8'hFF, 20);
    chk("dec_de", n_de - b_de, 1);
    chk("dec_se", n_se - b_se, 0);
    chk("dec_no_vv", n_vv - b_vv, 0);
    chk("dec_value_held", value, 16'h00A0);
    dig(4'hE, 8'h80, 20); dig(4'hD, 8'hF8, 20); dig(4'hB, 8'h82, 20); dig(4'h7, 8'h92, 20);
    dig(4'hF, 8'hFF, 20);
    chk("f5678_count", n_vv - b_vv, 1);
    chk("f5678_value", value, 16'h5678);
    chk("f5678_dp", dp, 0);
    dig(4'hE, 8'h80, 20); dig(4'hD, 8'hF8, 20);
    @(negedge clk);
    rst = 1'b1;
    an = 4'hF;
    hex_display = 8'hFF;
    @(negedge clk);
    chk("midrst_value", value, 0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("idle_value", value, 0);
    chk("idle_dp", dp, 0);
    chk("idle_stale", stale, 1);
    dig(4'hE, 8'h99, 20); dig(4'hD, 8'hB0, 20); dig(4'hB, 8'hA4, 20);
    fin(4'h7, 8'hF9, "rec");
    dig(4'hF, 8'hFF, 20);
    chk("rec_value", value, 16'h1234);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
